cpu_bus_tracer: RTL and testbench

Passive monitor on the cpu6502 external bus, downstream of the CPU's addr/odata/idata/rw/clk2 outputs. It detects the end of each phi2 phase and captures the completed bus cycle: direction, address, data and a phi2 cycle stamp. Captured cycles go into a first-word-fall-through FIFO drained over a valid/ready port. Benches and on-chip debug logic use it to check stores (e.g. STA $99 ← $FF) without probing CPU internals.

---
 rtl/cpu_bus_tracer.sv | 93 +++++++++
 tb/tb_cpu_bus_tracer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_tracer.sv
// rtl/cpu_bus_tracer.sv - passive cpu6502 bus monitor with FWFT trace FIFO
module cpu_bus_tracer #(
   parameter int DEPTH       = 16,
   parameter bit WRITES_ONLY = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [15:0]                cpu_addr,
   input  logic [7:0]                 cpu_idata,
   input  logic [7:0]                 cpu_odata,
   input  logic                       cpu_rw,
   input  logic                       cpu_clk2,
   input  logic                       enable,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic                       trace_rw,
   output logic [15:0]                trace_addr,
   output logic [7:0]                 trace_data,
   output logic [15:0]                trace_cycle,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [7:0]                 drop_count,
   input  logic                       clear_overflow
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   logic          clk2_q;
   logic [15:0]   cycle_cnt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [40:0]   mem [DEPTH];

   logic          fall;
   logic          capture;
   logic          full;
   logic          do_pop;
   logic          do_push;
   logic          drop;
   logic [7:0]    bus_data;
   logic [40:0]   entry;
   logic [7:0]    drop_next;

   assign fall        = clk2_q & ~cpu_clk2;
   assign capture     = fall & enable & (~cpu_rw | ~WRITES_ONLY);
   assign trace_valid = (level != '0);
   assign full        = (level == FULL_LVL);
   assign do_pop      = trace_valid & trace_ready;
   // A full FIFO can still accept when the head leaves on the same edge.
   assign do_push     = capture & (~full | do_pop);
   assign drop        = capture & full & ~do_pop;
   assign bus_data    = cpu_rw ? cpu_idata : cpu_odata;
   assign entry       = {cpu_rw, cpu_addr, bus_data, cycle_cnt};
   assign drop_next   = (drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1;

   assign {trace_rw, trace_addr, trace_data, trace_cycle} = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk2_q     <= 1'b0;
         cycle_cnt  <= 16'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         clk2_q <= cpu_clk2;
         if (fall) begin
            cycle_cnt <= cycle_cnt + 16'd1;
         end
         if (do_push) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
         // A drop on the clearing edge restarts the count at one.
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_overflow ? 8'd1 : drop_next;
         end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_cpu_bus_tracer.sv
// tb/tb_cpu_bus_tracer.sv - directed self-checking bench for cpu_bus_tracer
module tb_cpu_bus_tracer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_idata, cpu_odata;
   logic        cpu_rw, cpu_clk2, enable;
   logic        ready_a, ready_b, clr;

   logic        a_valid, a_rw, a_ovf;
   logic [15:0] a_addr, a_cycle;
   logic [7:0]  a_data, a_drop;
   logic [4:0]  a_level;

   logic        b_valid, b_rw, b_ovf;
   logic [15:0] b_addr, b_cycle;
   logic [7:0]  b_data, b_drop;
   logic [2:0]  b_level;

   int errors = 0;
   int checks = 0;

   cpu_bus_tracer #(.DEPTH(16), .WRITES_ONLY(1'b1)) dut_a (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_idata(cpu_idata),
      .cpu_odata(cpu_odata), .cpu_rw(cpu_rw), .cpu_clk2(cpu_clk2), .enable(enable),
      .trace_valid(a_valid), .trace_ready(ready_a), .trace_rw(a_rw),
      .trace_addr(a_addr), .trace_data(a_data), .trace_cycle(a_cycle),
      .level(a_level), .overflow(a_ovf), .drop_count(a_drop), .clear_overflow(clr)
   );

   cpu_bus_tracer #(.DEPTH(4), .WRITES_ONLY(1'b0)) dut_b (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_idata(cpu_idata),
      .cpu_odata(cpu_odata), .cpu_rw(cpu_rw), .cpu_clk2(cpu_clk2), .enable(enable),
      .trace_valid(b_valid), .trace_ready(ready_b), .trace_rw(b_rw),
      .trace_addr(b_addr), .trace_data(b_data), .trace_cycle(b_cycle),
      .level(b_level), .overflow(b_ovf), .drop_count(b_drop), .clear_overflow(clr)
   );

   // LDA #$01 ; ORA $44 ; STA $99 as seen on the bus, with mem[$44] = $FE
   logic [15:0] pa [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                           16'h0044, 16'h0004, 16'h0005, 16'h0099};
   logic [7:0]  pd [8] = '{8'hA9, 8'h01, 8'h05, 8'h44, 8'hFE, 8'h85, 8'h99, 8'hFF};
   logic        pr [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [15:0] drain_stamp [4] = '{16'd1, 16'd2, 16'd3, 16'd6};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic phi_start(input logic r, input logic [15:0] ad, input logic [7:0] d);
      @(negedge clk);
      cpu_rw   = r;
      cpu_addr = ad;
      if (r) begin
         cpu_idata = d;
         cpu_odata = 8'h00;
      end else begin
         cpu_odata = d;
         cpu_idata = 8'h5A;
      end
      cpu_clk2 = 1'b1;
      @(negedge clk);
      cpu_clk2 = 1'b0;
   endtask

   task automatic phi_end();
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; cpu_addr = '0; cpu_idata = '0; cpu_odata = '0;
      cpu_rw = 1'b1; cpu_clk2 = 1'b0; enable = 1'b1;
      ready_a = 1'b0; ready_b = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", a_valid, 0);
      chk("rst_level", a_level, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_cycle", b_cycle, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_drop", a_drop, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("release_no_edge", b_level, 0);

      // program trace: dut_a keeps only the store, dut_b drains every cycle
      ready_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         phi_start(pr[i], pa[i], pd[i]);
         if (i == 7) chk("t1_valid_before_fall", a_valid, 0);
         phi_end();
         chk("t2_valid", b_valid, 1);
         chk("t2_rw", b_rw, pr[i]);
         chk("t2_addr", b_addr, pa[i]);
         chk("t2_data", b_data, pd[i]);
         chk("t2_cycle", b_cycle, i);
      end
      chk("t1_valid", a_valid, 1);
      chk("t1_level", a_level, 1);
      chk("t1_rw", a_rw, 0);
      chk("t1_addr", a_addr, 16'h0099);
      chk("t1_data", a_data, 8'hFF);
      chk("t1_cycle", a_cycle, 7);
      @(negedge clk);
      chk("t2_drained", b_level, 0);
      ready_b = 1'b0;
      ready_a = 1'b1;
      @(negedge clk);
      ready_a = 1'b0;
      chk("t1_drained", a_level, 0);

      // overflow on the 4-deep instance
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         phi_start(1'b1, 16'h0100 + 16'(i), 8'(i));
         phi_end();
      end
      chk("t3_level", b_level, 4);
      chk("t3_ovf", b_ovf, 1);
      chk("t3_drop", b_drop, 2);
      chk("t3_head", b_cycle, 0);

      phi_start(1'b1, 16'h0200, 8'h77);
      ready_b = 1'b1;
      phi_end();
      ready_b = 1'b0;
      chk("t4_level", b_level, 4);
      chk("t4_drop_kept", b_drop, 2);
      chk("t4_head", b_cycle, 1);
      phi_start(1'b1, 16'h0201, 8'h78);
      clr = 1'b1;
      phi_end();
      clr = 1'b0;
      chk("t4_clr_drop_ovf", b_ovf, 1);
      chk("t4_clr_drop_cnt", b_drop, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t4_clr_ovf", b_ovf, 0);
      chk("t4_clr_cnt", b_drop, 0);
      ready_b = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("t4_drain_cycle", b_cycle, drain_stamp[j]);
         @(negedge clk);
      end
      ready_b = 1'b0;
      chk("t4_empty_level", b_level, 0);
      chk("t4_empty_valid", b_valid, 0);

      // enable gating; stamps keep counting while disabled
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         phi_start(1'b0, 16'h0300 + 16'(i), 8'hA0);
         phi_end();
         chk("t5_off_a", a_level, 0);
         chk("t5_off_b", b_level, 0);
      end
      enable = 1'b1;
      phi_start(1'b0, 16'h0310, 8'hC3);
      phi_end();
      chk("t5_a_cycle", a_cycle, 3);
      chk("t5_a_addr", a_addr, 16'h0310);
      chk("t5_a_data", a_data, 8'hC3);
      chk("t5_b_cycle", b_cycle, 3);
      phi_start(1'b1, 16'h0320, 8'h11);
      phi_end();
      chk("t6_queued", b_level, 2);

      // asynchronous reset mid-phi2 with clk2 low at release
      phi_start(1'b1, 16'h0330, 8'h22);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_valid", b_valid, 0);
      chk("t6_async_level", b_level, 0);
      chk("t6_async_level_a", a_level, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_no_false_edge", b_level, 0);
      phi_start(1'b1, 16'h0340, 8'h33);
      phi_end();
      chk("t6_restamp", b_cycle, 0);
      chk("t6_addr", b_addr, 16'h0340);

      // stamp wrap
      ready_b = 1'b1;
      @(negedge clk);
      ready_b = 1'b0;
      chk("t7_empty", b_level, 0);
      force dut_b.cycle_cnt = 16'hFFFF;
      @(negedge clk);
      release dut_b.cycle_cnt;
      phi_start(1'b1, 16'h0350, 8'h44);
      phi_end();
      phi_start(1'b1, 16'h0351, 8'h45);
      phi_end();
      chk("t7_level", b_level, 2);
      chk("t7_stamp_ffff", b_cycle, 16'hFFFF);
      ready_b = 1'b1;
      @(negedge clk);
      ready_b = 1'b0;
      chk("t7_stamp_0000", b_cycle, 16'h0000);
      chk("t7_addr", b_addr, 16'h0351);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
